// File: rtl/aes128_dec_key_sched.sv
// rtl/aes128_dec_key_sched.sv - iterative AES-128 decryption key scheduler
//
// Ports:
//   Clk        : rising-edge clock
//   Rst        : asynchronous active-high reset
//   i_Key      : 128-bit cipher key, w0 in [127:96], first byte in [127:120]
//   i_fStart   : one-cycle pulse, load i_Key and start forward expansion
//   i_fNext    : consume current round key, step back one round
//   o_RoundKey : current round key, same packing as i_Key
//   o_Round    : round index of o_RoundKey (10..0)
//   o_fValid   : o_RoundKey/o_Round valid
//   o_fBusy    : block not idle

module aes128_dec_key_sched (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [127:0] i_Key,
    input  logic         i_fStart,
    input  logic         i_fNext,
    output logic [127:0] o_RoundKey,
    output logic [3:0]   o_Round,
    output logic         o_fValid,
    output logic         o_fBusy
);

    typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;

    // Forward FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t       state;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         busy_q;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sw_in, sw_out;
    logic [3:0]  r_fwd;
    logic [127:0] key_fwd, key_inv;

    always_comb begin
        {w0, w1, w2, w3} = key_q;
        r_fwd = round_q + 4'd1;

        // Previous-round words recovered by undoing the w1..w3 XOR chain.
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;

        // One S-box word shared: forward step feeds w3, inverse feeds p3
        // (which is the previous round's w3). Both are RotWord'ed.
        sw_in  = (state == EXPAND) ? {w3[23:0], w3[31:24]} : {p3[23:0], p3[31:24]};
        sw_out = sub_word(sw_in);

        key_fwd[127:96] = w0 ^ sw_out ^ {rcon(r_fwd), 24'h0};
        key_fwd[95:64]  = w1 ^ key_fwd[127:96];
        key_fwd[63:32]  = w2 ^ key_fwd[95:64];
        key_fwd[31:0]   = w3 ^ key_fwd[63:32];

        p0 = w0 ^ sw_out ^ {rcon(round_q), 24'h0};
        key_inv = {p0, p1, p2, p3};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (i_fStart) begin
            // Start overrides everything, including a simultaneous i_fNext.
            state   <= EXPAND;
            key_q   <= i_Key;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                EXPAND: begin
                    key_q   <= key_fwd;
                    round_q <= r_fwd;
                    if (r_fwd == 4'd10) begin
                        state   <= OUT;
                        valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (i_fNext) begin
                        if (round_q != 4'd0) begin
                            key_q   <= key_inv;
                            round_q <= round_q - 4'd1;
                        end else begin
                            // K0 consumed; key register keeps K0.
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_RoundKey = key_q;
    assign o_Round    = round_q;
    assign o_fValid   = valid_q;
    assign o_fBusy    = busy_q;

endmodule

// File: doc/aes128_dec_key_sched.md
# aes128_dec_key_sched

Iterative AES-128 decryption key scheduler. Takes the 128-bit cipher key and expands it forward to the round-10 key. It then hands out round keys in reverse order, 10 down to 0, one per request, by inverting the FIPS-197 expansion. It sits beside the round datapath, which runs with the encrypt flag low (inverse ShiftRows/SubBytes/MixColumns), and supplies the per-round AddRoundKey operand without storing all 11 keys.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- Clk        input   1    rising-edge clock
- Rst        input   1    asynchronous reset, active-high
- i_Key      input   128  cipher key; bits [127:96] = w0, first key byte at [127:120]
- i_fStart   input   1    one-cycle pulse, load i_Key and begin expansion
- i_fNext    input   1    consume current round key, step to previous round
- o_RoundKey output  128  current round key, same byte packing as i_Key
- o_Round    output  4    round index of o_RoundKey (10..0)
- o_fValid   output  1    o_RoundKey/o_Round valid
- o_fBusy    output  1    block not idle (EXPAND or OUT)

## Operation
- States: IDLE, EXPAND, OUT.
- Reset, asynchronous, active-high:
  - state = IDLE, key register = 0, round counter = 0.
  - o_RoundKey = 0, o_Round = 0, o_fValid = 0, o_fBusy = 0.
- i_fStart in any state, priority over i_fNext:
  - key register ← i_Key, round ← 0, state ← EXPAND.
  - A restart mid-expansion or mid-readout discards all progress.
- EXPAND, one forward step per cycle with r = round+1:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - round ← r; when r = 10, state ← OUT.
- OUT:
  - o_fValid = 1; o_RoundKey = key register; o_Round = round.
  - i_fNext with round > 0, inverse step using r = round:
    - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
    - round ← r−1.
  - i_fNext with round = 0: state ← IDLE, o_fValid ← 0, key register retained.
- IDLE: i_fNext is ignored.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. All other indices are never used.
- SubWord: four forward FIPS-197 S-box lookups, combinational, shared by forward and inverse steps. The forward step takes RotWord(w3); the inverse step takes RotWord(p3).
- o_fBusy = (state != IDLE).
- All arithmetic is bytewise XOR; no carries.

## Timing
- Edge E0 samples i_fStart: o_fBusy = 1 from E0, o_fValid = 0.
- Expansion runs on edges E1..E10. o_Round counts 0→10 internally but is not valid.
- After E10: o_fValid = 1, o_Round = 10, o_RoundKey = K10. Start-to-valid latency is 10 clocks.
- Each sampled i_fNext updates o_RoundKey/o_Round at that same edge, visible in the next cycle. Back-to-back i_fNext yields one key per cycle.
- Readout covers 11 keys (K10..K0). The 11th i_fNext, consuming K0, drops o_fValid and o_fBusy after that edge.
- Outputs are registered; no combinational path from i_fNext or i_fStart to any output.
- i_fStart and i_fNext in the same cycle: start wins, i_fNext is lost.
- Rst asserted mid-EXPAND or mid-OUT forces the reset values immediately (asynchronous). Operation resumes only on a new i_fStart after Rst deasserts.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse i_fStart:
  - o_fValid rises exactly 10 clocks later.
  - o_Round = 10, o_RoundKey = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, 10 back-to-back i_fNext pulses:
  - Keys follow the FIPS-197 schedule in reverse, ending at o_Round = 1 = a0fafe1788542cb123a339392a6c7605, then o_Round = 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - The 11th i_fNext drops o_fValid and o_fBusy.
- Gapped readout (i_fNext every 3rd cycle): identical key sequence; o_RoundKey and o_Round are stable between requests.
- Key 000102030405060708090a0b0c0d0e0f: round-10 key = 13111d7fe3944a17f307a78b4d2b30c5; the final key read back equals i_Key.
- i_fStart during OUT at o_Round = 6 with a new key: o_fValid drops next cycle and re-rises 10 clocks later with the new K10. i_fStart together with i_fNext: the new expansion starts.
- Rst pulsed at EXPAND cycle 5: all outputs are 0 immediately. i_fNext in IDLE has no effect. A later i_fStart reproduces the first scenario exactly.
